input_vc_buffer: RTL and testbench
==================================

// Module: input_vc_buffer
// PURPOSE
// - One virtual-channel buffer of a router input port; VC_NUM instances per port feed the switch allocator.
// - Stores incoming flits and tracks packet state (IDLE/VA/ACTIVE).
// - Presents switch_request/out_port/downstream_vc to the allocator and pops a flit on its grant.
// - Drives on/off flow control back to the upstream router.
// PARAMETERS
// - BUFFER_SIZE    8  flit slots; power of 2, >=4
// - OFF_THRESHOLD  6  occupancy at/above which on_off_o drops to 0
// - ON_THRESHOLD   3  occupancy at/below which on_off_o returns to 1; must be < OFF_THRESHOLD
// PORTS
// - clk              in   1          clock; all state on rising edge
// - rst              in   1          synchronous, active-high reset
// - data_i           in   flit_t     incoming flit
// - write_i          in   1          push data_i this cycle
// - read_i           in   1          pop front flit (allocator valid_sel & vc_sel match this VC)
// - out_port_i       in   port_t     route-computation result for the current front head flit
// - vc_valid_i       in   1          VC allocation granted this cycle
// - vc_new_i         in   VC_SIZE    granted downstream VC; sampled with vc_valid_i
// - data_o           out  flit_t     front flit (combinational from buffer; 'x'-free: zeroed when empty)
// - out_port_o       out  port_t     registered output port of the current packet
// - downstream_vc_o  out  VC_SIZE    registered downstream VC of the current packet
// - vc_request_o     out  1          state==VA
// - switch_request_o out  1          state==ACTIVE && !is_empty_o
// - on_off_o         out  1          1 = upstream may send to this VC
// - is_full_o        out  1          occupancy==BUFFER_SIZE
// - is_empty_o       out  1          occupancy==0
// - error_o          out  1          protocol violation pulse (1 cycle)
// BEHAVIOUR
// - Reset: buffer empty; state IDLE; out_port_o=0; downstream_vc_o=0; on_off_o=1; error_o=0.
//   Reset mid-packet discards all content; no partial state survives.
// - Write: flit appears at data_o the cycle after write_i (min latency 1). Write when full and no read
//   -> flit dropped, error_o=1. Write+read same cycle when full -> both succeed, occupancy unchanged.
// - Read: read_i honoured only if switch_request_o=1; otherwise ignored, error_o=1.
// - Pointers: log2(BUFFER_SIZE)-bit, wrap modulo BUFFER_SIZE.
//   Occupancy counter is log2(BUFFER_SIZE)+1 bits.
// - FSM:
//   IDLE->VA: buffer non-empty and front label HEAD/HEADTAIL; latch out_port_o<=out_port_i.
//   IDLE with front BODY/TAIL: error_o=1 each cycle, flit not consumed.
//   VA->ACTIVE: on vc_valid_i; latch downstream_vc_o<=vc_new_i. vc_valid_i outside VA ignored.
//   ACTIVE->IDLE: on read_i of a TAIL/HEADTAIL flit.
//   The next packet's head is evaluated in the following cycle (1-cycle bubble, deliberate).
//   ACTIVE with empty buffer: stay ACTIVE, switch_request_o=0 (body flits still in flight).
// - on_off_o: registered hysteresis on next-cycle occupancy.
//   Goes 0 when occ>=OFF_THRESHOLD; goes 1 when occ<=ON_THRESHOLD; else holds.
//   OFF_THRESHOLD leaves >=2 slots for in-flight flits (round-trip 2 cycles).
// STRUCTURE
// - noc_params package: flit_label_t {HEAD,BODY,TAIL,HEADTAIL}, flit_t, port_t, VC_SIZE, PORT_SIZE.
//   Also an FSM enum vc_state_t {IDLE,VA,ACTIVE}.
// - Sub-module circular_buffer #(BUFFER_SIZE): data/write/read/full/empty/occupancy, no packet knowledge.
// - input_vc_buffer = circular_buffer + FSM + route/VC registers + on/off logic.
// TESTING
// - After reset: on_off_o=1, is_empty_o=1, all requests 0, error_o=0.
// - Packet HEAD(out_port=2),BODY,TAIL; vc_valid_i with vc_new_i=1 -> vc_request_o 1 cycle after write.
//   Then switch_request_o with out_port_o=2, downstream_vc_o=1; three reads -> IDLE, empty.
// - HEADTAIL single flit -> IDLE->VA->ACTIVE->IDLE after one read.
//   Back-to-back second head -> VA one cycle after the tail read.
// - Fill to 6 -> on_off_o=0 next cycle; drain to 3 -> on_off_o=1; fill to 8 plus write -> drop, error_o=1.
// - Full buffer with simultaneous write+read -> occupancy stays 8, no error, FIFO order kept across wrap.
// - BODY at front in IDLE -> error_o; read_i while in VA -> ignored, error_o; rst mid-packet -> reset values.

Source files
------------

// File: rtl/noc_params.sv
// Shared NoC types: flit format, port/VC widths and the input-VC packet state.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package noc_params;

  localparam int VC_NUM    = 4;
  localparam int VC_SIZE   = $clog2(VC_NUM);
  localparam int PORT_NUM  = 5;
  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef logic [PORT_SIZE-1:0] port_t;

  typedef struct packed {
    flit_label_t        label;
    logic [VC_SIZE-1:0] vc_id;
    logic [DATA_W-1:0]  data;
  } flit_t;

  localparam int FLIT_W = $bits(flit_t);

  typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

  function automatic logic is_head(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/circular_buffer.sv
// Generic power-of-2 circular FIFO with occupancy count; no packet knowledge.
// Latency: write visible at data_o the next cycle; data_o is combinational from the head slot.
// Backpressure: write refused when full unless a read pops in the same cycle; read of empty ignored.
module circular_buffer #(
  parameter int BUFFER_SIZE = 8,
  parameter int DATA_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         write_i,
  input  logic                         read_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         is_full_o,
  output logic                         is_empty_o,
  output logic [$clog2(BUFFER_SIZE):0] occupancy_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);

  logic [DATA_W-1:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    occ;
  logic              do_read;
  logic              do_write;

  assign is_empty_o  = (occ == '0);
  assign is_full_o   = (occ == (PTR_W+1)'(BUFFER_SIZE));
  assign occupancy_o = occ;
  assign do_read     = read_i && !is_empty_o;
  assign do_write    = write_i && (!is_full_o || do_read);

  // Zeroed when empty so downstream never sees stale or unknown slot contents.
  assign data_o = is_empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (PTR_W+1)'(do_write) - (PTR_W+1)'(do_read);
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/input_vc_buffer.sv
// One router input virtual channel: flit FIFO, packet FSM, route/VC latches, on/off flow control.
// Latency: flit at data_o 1 cycle after write; head reaches VA 1 cycle after it is at the front.
// Backpressure: on/off hysteresis to upstream; overflow writes dropped and flagged on error_o.
module input_vc_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE   = 8,
  parameter int OFF_THRESHOLD = 6,
  parameter int ON_THRESHOLD  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_t              data_i,
  input  logic               write_i,
  input  logic               read_i,
  input  port_t              out_port_i,
  input  logic               vc_valid_i,
  input  logic [VC_SIZE-1:0] vc_new_i,
  output flit_t              data_o,
  output port_t              out_port_o,
  output logic [VC_SIZE-1:0] downstream_vc_o,
  output logic               vc_request_o,
  output logic               switch_request_o,
  output logic               on_off_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic               error_o
);

  localparam int OCC_W = $clog2(BUFFER_SIZE) + 1;

  vc_state_t          state;
  vc_state_t          state_next;
  port_t              out_port_next;
  logic [VC_SIZE-1:0] downstream_vc_next;
  logic               error_next;
  logic               on_off_next;
  logic [FLIT_W-1:0]  front_raw;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W-1:0]   occ_next;
  logic               read_ok;
  logic               write_ok;

  circular_buffer #(
    .BUFFER_SIZE (BUFFER_SIZE),
    .DATA_W      (FLIT_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .write_i     (write_i),
    .read_i      (read_ok),
    .data_o      (front_raw),
    .is_full_o   (is_full_o),
    .is_empty_o  (is_empty_o),
    .occupancy_o (occ)
  );

  assign data_o           = flit_t'(front_raw);
  assign vc_request_o     = (state == VA);
  assign switch_request_o = (state == ACTIVE) && !is_empty_o;
  assign read_ok          = read_i && switch_request_o;
  assign write_ok         = write_i && (!is_full_o || read_ok);
  assign occ_next         = occ + OCC_W'(write_ok) - OCC_W'(read_ok);

  always_comb begin
    state_next         = state;
    out_port_next      = out_port_o;
    downstream_vc_next = downstream_vc_o;
    error_next         = (read_i && !switch_request_o) || (write_i && !write_ok);
    case (state)
      IDLE: begin
        if (!is_empty_o) begin
          if (is_head(data_o.label)) begin
            state_next    = VA;
            out_port_next = out_port_i;
          end else begin
            // A body/tail with no head in front is left in place so it stays visible.
            error_next = 1'b1;
          end
        end
      end
      VA: begin
        if (vc_valid_i) begin
          state_next         = ACTIVE;
          downstream_vc_next = vc_new_i;
        end
      end
      ACTIVE: begin
        if (read_ok && is_tail(data_o.label)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    on_off_next = on_off_o;
    if (occ_next >= OCC_W'(OFF_THRESHOLD))     on_off_next = 1'b0;
    else if (occ_next <= OCC_W'(ON_THRESHOLD)) on_off_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      out_port_o      <= '0;
      downstream_vc_o <= '0;
      on_off_o        <= 1'b1;
      error_o         <= 1'b0;
    end else begin
      state           <= state_next;
      out_port_o      <= out_port_next;
      downstream_vc_o <= downstream_vc_next;
      on_off_o        <= on_off_next;
      error_o         <= error_next;
    end
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Directed bench for input_vc_buffer: packet flow, flow control, overflow, wrap, protocol errors.
module tb_input_vc_buffer;
  import noc_params::*;

  logic               clk = 1'b0;
  logic               rst;
  flit_t              data_i;
  logic               write_i;
  logic               read_i;
  port_t              out_port_i;
  logic               vc_valid_i;
  logic [VC_SIZE-1:0] vc_new_i;
  flit_t              data_o;
  port_t              out_port_o;
  logic [VC_SIZE-1:0] downstream_vc_o;
  logic               vc_request_o;
  logic               switch_request_o;
  logic               on_off_o;
  logic               is_full_o;
  logic               is_empty_o;
  logic               error_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_vc_buffer #(
    .BUFFER_SIZE   (8),
    .OFF_THRESHOLD (6),
    .ON_THRESHOLD  (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data_i),
    .write_i          (write_i),
    .read_i           (read_i),
    .out_port_i       (out_port_i),
    .vc_valid_i       (vc_valid_i),
    .vc_new_i         (vc_new_i),
    .data_o           (data_o),
    .out_port_o       (out_port_o),
    .downstream_vc_o  (downstream_vc_o),
    .vc_request_o     (vc_request_o),
    .switch_request_o (switch_request_o),
    .on_off_o         (on_off_o),
    .is_full_o        (is_full_o),
    .is_empty_o       (is_empty_o),
    .error_o          (error_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mk(input flit_label_t label, input logic [15:0] d);
    flit_t f;
    f.label = label;
    f.vc_id = '0;
    f.data  = d;
    return f;
  endfunction

  task automatic wr(input flit_label_t label, input logic [15:0] d);
    write_i = 1'b1;
    data_i  = mk(label, d);
    tick();
    write_i = 1'b0;
  endtask

  task automatic rd();
    read_i = 1'b1;
    tick();
    read_i = 1'b0;
  endtask

  task automatic grant_vc(input logic [VC_SIZE-1:0] vc);
    vc_valid_i = 1'b1;
    vc_new_i   = vc;
    tick();
    vc_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_on_off"},   32'(on_off_o), 1);
    check({tag, "_empty"},    32'(is_empty_o), 1);
    check({tag, "_full"},     32'(is_full_o), 0);
    check({tag, "_vc_req"},   32'(vc_request_o), 0);
    check({tag, "_sw_req"},   32'(switch_request_o), 0);
    check({tag, "_err"},      32'(error_o), 0);
    check({tag, "_out_port"}, 32'(out_port_o), 0);
    check({tag, "_dvc"},      32'(downstream_vc_o), 0);
    check({tag, "_data_o"},   32'(data_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] drain_exp [8];
    rst        = 1'b1;
    data_i     = '0;
    write_i    = 1'b0;
    read_i     = 1'b0;
    out_port_i = '0;
    vc_valid_i = 1'b0;
    vc_new_i   = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("reset");

    // Three-flit packet: HEAD, BODY, TAIL routed to port 2 on downstream VC 1.
    out_port_i = 3'd2;
    wr(HEAD, 16'h11);
    check("pkt_vc_req_early", 32'(vc_request_o), 0);
    check("pkt_front_label",  32'(data_o.label), 32'(HEAD));
    wr(BODY, 16'h12);
    check("pkt_vc_req",   32'(vc_request_o), 1);
    check("pkt_out_port", 32'(out_port_o), 2);
    out_port_i = 3'd0;
    wr(TAIL, 16'h13);
    grant_vc(2'd1);
    check("pkt_sw_req",        32'(switch_request_o), 1);
    check("pkt_vc_req_off",    32'(vc_request_o), 0);
    check("pkt_dvc",           32'(downstream_vc_o), 1);
    check("pkt_out_port_held", 32'(out_port_o), 2);
    check("pkt_front0",        32'(data_o.data), 32'h11);
    rd();
    check("pkt_front1", 32'(data_o.data), 32'h12);
    rd();
    check("pkt_front2", 32'(data_o.data), 32'h13);
    check("pkt_sw_req_tail", 32'(switch_request_o), 1);
    rd();
    check("pkt_done_vc_req", 32'(vc_request_o), 0);
    check("pkt_done_sw_req", 32'(switch_request_o), 0);
    check("pkt_done_empty",  32'(is_empty_o), 1);
    check("pkt_done_err",    32'(error_o), 0);

    // Single-flit packet followed immediately by the next head.
    do_reset();
    out_port_i = 3'd1;
    wr(HEADTAIL, 16'h21);
    wr(HEAD, 16'h22);
    check("ht_vc_req", 32'(vc_request_o), 1);
    grant_vc(2'd3);
    check("ht_sw_req",   32'(switch_request_o), 1);
    check("ht_dvc",      32'(downstream_vc_o), 3);
    check("ht_out_port", 32'(out_port_o), 1);
    out_port_i = 3'd4;
    rd();
    check("ht_idle_vc_req", 32'(vc_request_o), 0);
    check("ht_idle_sw_req", 32'(switch_request_o), 0);
    check("ht_next_front",  32'(data_o.data), 32'h22);
    tick();
    check("b2b_vc_req",   32'(vc_request_o), 1);
    check("b2b_out_port", 32'(out_port_o), 4);

    // On/off hysteresis and overflow.
    do_reset();
    wr(HEAD, 16'h30);
    for (int i = 1; i < 5; i++) wr(BODY, 16'h30 + 16'(i));
    check("occ5_on", 32'(on_off_o), 1);
    wr(BODY, 16'h35);
    check("occ6_off", 32'(on_off_o), 0);
    grant_vc(2'd2);
    rd();
    rd();
    check("occ4_still_off", 32'(on_off_o), 0);
    rd();
    check("occ3_on", 32'(on_off_o), 1);
    for (int i = 0; i < 5; i++) wr(BODY, 16'h36 + 16'(i));
    check("fill8_full",   32'(is_full_o), 1);
    check("fill8_off",    32'(on_off_o), 0);
    check("fill8_no_err", 32'(error_o), 0);
    wr(BODY, 16'h3B);
    check("drop_err",   32'(error_o), 1);
    check("drop_full",  32'(is_full_o), 1);
    check("drop_front", 32'(data_o.data), 32'h33);
    tick();
    check("drop_err_pulse", 32'(error_o), 0);

    // Simultaneous write+read while full, crossing the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      check("wrap_front", 32'(data_o.data), 32'h33 + 32'(i));
      write_i = 1'b1;
      read_i  = 1'b1;
      data_i  = mk(BODY, 16'h3C + 16'(i));
      tick();
      write_i = 1'b0;
      read_i  = 1'b0;
      check("wrap_full", 32'(is_full_o), 1);
      check("wrap_err",  32'(error_o), 0);
    end
    drain_exp = '{16'h37, 16'h38, 16'h39, 16'h3A, 16'h3C, 16'h3D, 16'h3E, 16'h3F};
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(data_o.data), 32'(drain_exp[i]));
      rd();
    end
    check("drain_empty",     32'(is_empty_o), 1);
    check("drain_on",        32'(on_off_o), 1);
    check("active_empty_sw", 32'(switch_request_o), 0);
    check("active_empty_va", 32'(vc_request_o), 0);

    // Protocol errors and reset mid-packet.
    do_reset();
    grant_vc(2'd2);
    check("vc_valid_idle_dvc", 32'(downstream_vc_o), 0);
    check("vc_valid_idle_sw",  32'(switch_request_o), 0);
    wr(BODY, 16'h40);
    check("body_first_err", 32'(error_o), 0);
    tick();
    check("body_idle_err", 32'(error_o), 1);
    tick();
    check("body_idle_err2",  32'(error_o), 1);
    check("body_idle_kept",  32'(is_empty_o), 0);
    check("body_idle_no_va", 32'(vc_request_o), 0);
    do_reset();
    out_port_i = 3'd2;
    wr(HEAD, 16'h41);
    tick();
    check("va_vc_req", 32'(vc_request_o), 1);
    rd();
    check("va_read_err",   32'(error_o), 1);
    check("va_read_kept",  32'(data_o.data), 32'h41);
    check("va_still_va",   32'(vc_request_o), 1);
    tick();
    check("va_err_pulse", 32'(error_o), 0);
    grant_vc(2'd1);
    wr(BODY, 16'h42);
    check("mid_pkt_sw_req", 32'(switch_request_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
